// File: rtl/fdiv_arbiter.sv
// Round-robin front end sharing one pipelined fdiv among N_REQ requesters.
// Tracks one outstanding divide per requester and counts accepted operations.
module fdiv_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned IDX_W   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_x1,
    input  logic [N_REQ*32-1:0]  req_x2,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31:0]          resp_y,
    output logic [31:0]          div_x1,
    output logic [31:0]          div_x2,
    input  logic [31:0]          div_y,
    output logic                 busy,
    output logic [31:0]          op_count
);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   outstanding_q, outstanding_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [IDX_W-1:0]   tag_idx_q [LATENCY];
    logic [IDX_W-1:0]   tag_idx_d [LATENCY];
    logic [31:0]        op_count_q, op_count_d;

    logic [N_REQ-1:0]   eligible;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   cand;
    logic               rsp_vld;
    logic [IDX_W-1:0]   rsp_idx;

    assign rsp_vld  = tag_vld_q[LATENCY-1];
    assign rsp_idx  = tag_idx_q[LATENCY-1];
    assign busy     = |outstanding_q;
    assign op_count = op_count_q;

    // Grant is gated by rstn so every output reads zero while reset is held.
    always_comb begin
        eligible = req_valid & ~outstanding_q & {N_REQ{rstn}};
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!gnt_vld && eligible[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        div_x1     = '0;
        div_x2     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_vld && gnt_idx == IDX_W'(i)) begin
                req_ready[i] = 1'b1;
                div_x1       = req_x1[32*i +: 32];
                div_x2       = req_x2[32*i +: 32];
            end
            if (rsp_vld && rsp_idx == IDX_W'(i)) begin
                resp_valid[i] = 1'b1;
            end
        end
        resp_y = rsp_vld ? div_y : '0;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (rsp_vld) outstanding_d[rsp_idx] = 1'b0;
        if (gnt_vld) outstanding_d[gnt_idx] = 1'b1;

        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        op_count_d = gnt_vld ? op_count_q + 32'd1 : op_count_q;

        tag_vld_d    = '0;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = gnt_vld;
        tag_idx_d[0] = gnt_idx;
        for (int unsigned s = 1; s < LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            tag_vld_q     <= '0;
            op_count_q    <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            tag_vld_q     <= tag_vld_d;
            tag_idx_q     <= tag_idx_d;
            op_count_q    <= op_count_d;
        end
    end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Directed bench for fdiv_arbiter: a LATENCY=1 and a LATENCY=4 instance share
// stimulus, each fed by a small table-based fdiv model.
module tb_fdiv_arbiter;

    localparam logic [31:0] S1  = 32'h3F80_0000;  // 1.0
    localparam logic [31:0] S2  = 32'h4000_0000;  // 2.0
    localparam logic [31:0] S4  = 32'h4080_0000;  // 4.0
    localparam logic [31:0] S6  = 32'h40C0_0000;  // 6.0
    localparam logic [31:0] Q3  = 32'h4040_0000;  // 3.0
    localparam logic [31:0] Q25 = 32'h3E80_0000;  // 0.25

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_x1 = '0;
    logic [127:0] req_x2 = '0;

    logic [3:0]  ready_a, resp_a, ready_b, resp_b;
    logic [31:0] y_a, dx1_a, dx2_a, divy_a, cnt_a;
    logic [31:0] y_b, dx1_b, dx2_b, divy_b, cnt_b;
    logic        busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fdiv_arbiter #(.N_REQ(4), .LATENCY(1)) u_a (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
        .req_ready(ready_a), .resp_valid(resp_a), .resp_y(y_a), .div_x1(dx1_a),
        .div_x2(dx2_a), .div_y(divy_a), .busy(busy_a), .op_count(cnt_a)
    );

    fdiv_arbiter #(.N_REQ(4), .LATENCY(4)) u_b (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
        .req_ready(ready_b), .resp_valid(resp_b), .resp_y(y_b), .div_x1(dx1_b),
        .div_x2(dx2_b), .div_y(divy_b), .busy(busy_b), .op_count(cnt_b)
    );

    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {S6, S2}:                       quot = Q3;
            {S1, S4}:                       quot = Q25;
            {S1, S2}:                       quot = 32'h3F00_0000;
            {32'hC110_0000, 32'h4040_0000}: quot = 32'hC040_0000;
            {32'h40A0_0000, 32'h3F00_0000}: quot = 32'h4120_0000;
            default:                        quot = a ^ b;
        endcase
    endfunction

    // fdiv models: sample operands at the edge, result LATENCY cycles later
    logic [31:0] pipe_a = '0;
    logic [31:0] pipe_b [4] = '{default: '0};
    always @(posedge clk) begin
        pipe_a    <= quot(dx1_a, dx2_a);
        pipe_b[0] <= quot(dx1_b, dx2_b);
        for (int s = 1; s < 4; s++) pipe_b[s] <= pipe_b[s-1];
    end
    assign divy_a = pipe_a;
    assign divy_b = pipe_b[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rstn = 1'b0;
        req_valid = '0;
        tick();
        rstn = 1'b1;
    endtask

    // Accept/response pairing per requester, checked on the falling edge
    int pend_a [4] = '{default: 0};
    int pend_b [4] = '{default: 0};
    always @(negedge clk) begin
        if (!rstn) begin
            pend_a = '{default: 0};
            pend_b = '{default: 0};
        end else begin
            if (!$onehot0(ready_a) || !$onehot0(resp_a) || !$onehot0(ready_b) || !$onehot0(resp_b)) begin
                n_tests++;
                n_fail++;
                $display("FAIL onehot: ready_a %b resp_a %b ready_b %b resp_b %b required one-hot or zero",
                         ready_a, resp_a, ready_b, resp_b);
            end
            for (int i = 0; i < 4; i++) begin
                if (resp_a[i]) begin
                    n_tests++;
                    if (pend_a[i] == 0) begin
                        n_fail++;
                        $display("FAIL unmatched_resp_a[%0d]: got response with 0 accepts pending, required >=1", i);
                    end else pend_a[i]--;
                end
                if (resp_b[i]) begin
                    n_tests++;
                    if (pend_b[i] == 0) begin
                        n_fail++;
                        $display("FAIL unmatched_resp_b[%0d]: got response with 0 accepts pending, required >=1", i);
                    end else pend_b[i]--;
                end
                if (ready_a[i]) pend_a[i]++;
                if (ready_b[i]) pend_b[i]++;
            end
        end
    end

    typedef struct {
        logic        rstn;
        logic [3:0]  valid;
        logic [31:0] x1, x2;
        logic [3:0]  ready, resp;
        logic [31:0] y;
        logic        busy;
        logic [31:0] cnt;
        logic [31:0] dx1;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] rd, input logic [3:0] rs, input logic [31:0] y,
                                input logic bz, input logic [31:0] c, input logic [31:0] d);
        vec_t t;
        t.rstn = r; t.valid = v; t.x1 = a; t.x2 = b; t.ready = rd; t.resp = rs;
        t.y = y; t.busy = bz; t.cnt = c; t.dx1 = d;
        return t;
    endfunction

    vec_t tbl [12];
    logic [3:0] e_rdy, e_rsp;

    initial begin
        // LATENCY=1 instance: single op on requester 1, then four-way round robin
        tbl[0]  = mk(0, 4'b1111, S1, S4, 4'b0000, 4'b0000, 0,   0, 0, 0);
        tbl[1]  = mk(1, 4'b0010, S6, S2, 4'b0010, 4'b0000, 0,   0, 0, S6);
        tbl[2]  = mk(1, 4'b0000, S6, S2, 4'b0000, 4'b0010, Q3,  1, 1, 0);
        tbl[3]  = mk(1, 4'b0000, S6, S2, 4'b0000, 4'b0000, 0,   0, 1, 0);
        tbl[4]  = mk(0, 4'b1111, S1, S4, 4'b0000, 4'b0000, 0,   0, 0, 0);
        tbl[5]  = mk(1, 4'b1111, S1, S4, 4'b0001, 4'b0000, 0,   0, 0, S1);
        tbl[6]  = mk(1, 4'b1111, S1, S4, 4'b0010, 4'b0001, Q25, 1, 1, S1);
        tbl[7]  = mk(1, 4'b1111, S1, S4, 4'b0100, 4'b0010, Q25, 1, 2, S1);
        tbl[8]  = mk(1, 4'b1111, S1, S4, 4'b1000, 4'b0100, Q25, 1, 3, S1);
        tbl[9]  = mk(1, 4'b1111, S1, S4, 4'b0001, 4'b1000, Q25, 1, 4, S1);
        tbl[10] = mk(1, 4'b0000, S1, S4, 4'b0000, 4'b0001, Q25, 1, 5, 0);
        tbl[11] = mk(1, 4'b0000, S1, S4, 4'b0000, 4'b0000, 0,   0, 5, 0);

        for (int i = 0; i < 12; i++) begin
            tick();
            rstn      = tbl[i].rstn;
            req_valid = tbl[i].valid;
            req_x1    = {4{tbl[i].x1}};
            req_x2    = {4{tbl[i].x2}};
            #3;
            chk($sformatf("row%0d.req_ready", i),  32'(ready_a), 32'(tbl[i].ready));
            chk($sformatf("row%0d.resp_valid", i), 32'(resp_a),  32'(tbl[i].resp));
            chk($sformatf("row%0d.busy", i),       32'(busy_a),  32'(tbl[i].busy));
            chk($sformatf("row%0d.op_count", i),   cnt_a,        tbl[i].cnt);
            chk($sformatf("row%0d.div_x1", i),     dx1_a,        tbl[i].dx1);
            chk($sformatf("row%0d.div_x2", i),     dx2_a,        (tbl[i].ready != 0) ? tbl[i].x2 : 32'h0);
            if (tbl[i].resp != 0 || !tbl[i].rstn)
                chk($sformatf("row%0d.resp_y", i), y_a, tbl[i].y);
        end

        // Fairness, requesters 0 and 2 always valid
        do_reset();
        req_valid = 4'b0101;
        req_x1 = {4{S1}};
        req_x2 = {4{S4}};
        for (int c = 0; c < 12; c++) begin
            #3;
            chk($sformatf("fair_a%0d.req_ready", c), 32'(ready_a), (c % 2 == 0) ? 32'h1 : 32'h4);
            chk($sformatf("fair_a%0d.resp_valid", c), 32'(resp_a), (c == 0) ? 32'h0 : ((c % 2 == 1) ? 32'h1 : 32'h4));
            e_rdy = (c % 5 == 0) ? 4'b0001 : (c % 5 == 1) ? 4'b0100 : 4'b0000;
            e_rsp = (c % 5 == 4) ? 4'b0001 : (c % 5 == 0 && c > 0) ? 4'b0100 : 4'b0000;
            chk($sformatf("fair_b%0d.req_ready", c), 32'(ready_b), 32'(e_rdy));
            chk($sformatf("fair_b%0d.resp_valid", c), 32'(resp_b), 32'(e_rsp));
            tick();
        end

        // Pipelining, LATENCY=4, three back-to-back issues
        do_reset();
        req_valid = 4'b0111;
        req_x1 = {32'h0, 32'h40A0_0000, 32'hC110_0000, S1};
        req_x2 = {32'h0, 32'h3F00_0000, 32'h4040_0000, S2};
        for (int c = 0; c < 8; c++) begin
            if (c == 3) req_valid = 4'b0000;
            #3;
            chk($sformatf("pipe%0d.req_ready", c), 32'(ready_b), (c < 3) ? (32'h1 << c) : 32'h0);
            chk($sformatf("pipe%0d.resp_valid", c), 32'(resp_b), (c >= 4 && c <= 6) ? (32'h1 << (c - 4)) : 32'h0);
            chk($sformatf("pipe%0d.busy", c), 32'(busy_b), (c >= 1 && c <= 6) ? 32'h1 : 32'h0);
            if (c == 4) chk("pipe.resp_y0", y_b, 32'h3F00_0000);
            if (c == 5) chk("pipe.resp_y1", y_b, 32'hC040_0000);
            if (c == 6) chk("pipe.resp_y2", y_b, 32'h4120_0000);
            if (c == 7) chk("pipe.op_count", cnt_b, 32'd3);
            tick();
        end

        // Reset in the middle of an in-flight LATENCY=4 op
        do_reset();
        req_valid = 4'b0010;
        req_x1 = {4{S1}};
        req_x2 = {4{S4}};
        #3;
        chk("mid.issue_ready", 32'(ready_b), 32'h2);
        tick();
        req_valid = 4'b0000;
        tick();
        rstn = 1'b0;
        req_valid = 4'b0011;
        #1;
        chk("mid.rst_ready", 32'(ready_b), 32'h0);
        chk("mid.rst_resp", 32'(resp_b), 32'h0);
        chk("mid.rst_y", y_b, 32'h0);
        chk("mid.rst_dx1", dx1_b, 32'h0);
        chk("mid.rst_dx2", dx2_b, 32'h0);
        chk("mid.rst_busy", 32'(busy_b), 32'h0);
        chk("mid.rst_cnt", cnt_b, 32'h0);
        tick();
        rstn = 1'b1;
        req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            #3;
            chk($sformatf("mid.post%0d.resp_valid", c), 32'(resp_b), 32'h0);
            tick();
        end
        req_valid = 4'b0011;
        #3;
        chk("mid.first_grant", 32'(ready_b), 32'h1);
        tick();
        req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) tick();

        // op_count wrap on the LATENCY=1 instance
        force u_a.op_count_q = 32'hFFFF_FFFF;
        #1;
        release u_a.op_count_q;
        chk("wrap.preload", cnt_a, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        #2;
        chk("wrap.ready", 32'(ready_a), 32'h1);
        tick();
        req_valid = 4'b0000;
        #3;
        chk("wrap.op_count", cnt_a, 32'h0);

        for (int c = 0; c < 6; c++) tick();
        #3;
        chk("balance_a", 32'(pend_a[0] + pend_a[1] + pend_a[2] + pend_a[3]), 32'h0);
        chk("balance_b", 32'(pend_b[0] + pend_b[1] + pend_b[2] + pend_b[3]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
